// File: rtl/instruction_struct_pkg.sv
// -----------------------------------------------------------------------------
// InstructionStruct
//   Types shared between the instruction/data path blocks and the memory
//   port arbiter.
//     read_t      : memory read strobe encoding
//     write_t     : memory write strobe encoding
//     mem_owner_t : which requester currently owns the memory port
//     arb_state_t : memory port arbiter FSM states
// -----------------------------------------------------------------------------
package InstructionStruct;

    typedef enum logic {
        read_off = 1'b0,
        read_on  = 1'b1
    } read_t;

    typedef enum logic {
        write_off = 1'b0,
        write_on  = 1'b1
    } write_t;

    typedef enum logic [1:0] {
        own_none  = 2'd0,
        own_fetch = 2'd1,
        own_data  = 2'd2,
        own_str   = 2'd3
    } mem_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-transaction memory port between three requesters:
//   instruction fetch, data load/store and the display string reader.
//   Fixed priority data > string > fetch, with a starvation override that
//   forces a fetch grant after STARVE_MAX consecutive non-fetch grants while
//   fetch is pending. A BUSY watchdog aborts a transaction after TIMEOUT_CYC
//   cycles without mem_ready and reports it with an err pulse instead of ack.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   f_req, f_addr             : fetch read request
//   d_req, d_we, d_addr,
//   d_wdata                   : data read (d_we=0) or write (d_we=1) request
//   s_req, s_addr             : string reader read request
//   f_ack, d_ack, s_ack       : one-cycle completion pulses
//   rdata                     : last completed read data (shared)
//   err                       : one-cycle timeout pulse
//   owner                     : current owner (mem_owner_t), own_none in IDLE
//   mem_addr, mem_read,
//   mem_write, mem_wdata      : memory request side
//   mem_rdata, mem_ready      : memory response side
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import InstructionStruct::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,

    input  logic              s_req,
    input  logic [ADDR_W-1:0] s_addr,

    output logic              f_ack,
    output logic              d_ack,
    output logic              s_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        owner,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);
    localparam logic [TMO_W-1:0]    TMO_LAST     = TMO_W'(TIMEOUT_CYC - 1);

    arb_state_t          state_q,  state_d;
    mem_owner_t          owner_q,  owner_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                we_q,     we_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [TMO_W-1:0]    tmo_q,    tmo_d;
    logic                err_q,    err_d;

    read_t               read_strobe;
    write_t              write_strobe;
    logic [2:0]          ack_vec;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= own_none;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            starve_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        err_d    = err_q;

        case (state_q)
            ARB_IDLE: begin
                tmo_d = '0;
                err_d = 1'b0;
                if (!f_req) begin
                    starve_d = '0;
                end

                if (f_req && (starve_q == STARVE_LIMIT)) begin
                    // Starvation override beats any data/string request.
                    state_d  = ARB_BUSY;
                    owner_d  = own_fetch;
                    addr_d   = f_addr;
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    starve_d = '0;
                end else if (d_req) begin
                    state_d = ARB_BUSY;
                    owner_d = own_data;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    if (f_req && (starve_q != STARVE_LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (s_req) begin
                    state_d = ARB_BUSY;
                    owner_d = own_str;
                    addr_d  = s_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    if (f_req && (starve_q != STARVE_LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (f_req) begin
                    state_d  = ARB_BUSY;
                    owner_d  = own_fetch;
                    addr_d   = f_addr;
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    starve_d = '0;
                end
            end

            ARB_BUSY: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ARB_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    // This was the TIMEOUT_CYC-th strobe cycle: abort.
                    err_d   = 1'b1;
                    state_d = ARB_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ARB_RESP: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign read_strobe  = (state_q == ARB_BUSY && !we_q) ? read_on  : read_off;
    assign write_strobe = (state_q == ARB_BUSY &&  we_q) ? write_on : write_off;

    assign mem_read  = read_strobe;
    assign mem_write = write_strobe;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign owner     = (state_q == ARB_IDLE) ? own_none : owner_q;
    assign err       = (state_q == ARB_RESP) && err_q;

    // ack_vec[0] = fetch (owner 1), [1] = data (owner 2), [2] = string (owner 3)
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ack
            assign ack_vec[gi] = (state_q == ARB_RESP) && !err_q &&
                                 (owner_q == mem_owner_t'(gi + 1));
        end
    endgenerate

    assign f_ack = ack_vec[0];
    assign d_ack = ack_vec[1];
    assign s_ack = ack_vec[2];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs are driven and outputs
//   sampled on the falling edge. A small memory responder raises mem_ready
//   after wait_cfg strobe cycles (0 = first BUSY cycle, 255 = never).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 8;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, d_req, d_we, s_req;
    logic [AW-1:0] f_addr, d_addr, s_addr;
    logic [DW-1:0] d_wdata;
    logic          f_ack, d_ack, s_ack, err;
    logic [DW-1:0] rdata;
    logic [1:0]    owner;
    logic [AW-1:0] mem_addr;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_txn    = 0;

    int            wait_cfg    = 0;
    int            busy_cnt    = 0;
    logic          resp_ready  = 1'b0;
    logic          ready_force = 1'b0;
    logic [DW-1:0] rdata_cfg   = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .s_req     (s_req),
        .s_addr    (s_addr),
        .f_ack     (f_ack),
        .d_ack     (d_ack),
        .s_ack     (s_ack),
        .rdata     (rdata),
        .err       (err),
        .owner     (owner),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Memory responder: counts strobe cycles, answers on strobe cycle wait_cfg+1.
    always @(negedge clk) begin
        if (mem_read === 1'b1 || mem_write === 1'b1) begin
            resp_ready <= (busy_cnt == wait_cfg);
            busy_cnt   <= busy_cnt + 1;
        end else begin
            resp_ready <= 1'b0;
            busy_cnt   <= 0;
        end
    end

    assign mem_ready = resp_ready | ready_force;
    assign mem_rdata = rdata_cfg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called on the falling edge of the IDLE cycle where the request is seen.
    // drop = {s,d,f}: requests released after the first BUSY cycle check.
    // Returns on the falling edge of the IDLE cycle after RESP.
    task automatic check_txn(input string tag, input logic [1:0] exp_owner,
                             input logic [31:0] exp_addr, input logic exp_wr,
                             input logic [31:0] exp_wdata, input int k,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input logic [2:0] drop);
        logic [2:0] exp_ack;
        case (exp_owner)
            2'd1:    exp_ack = 3'b001;
            2'd2:    exp_ack = 3'b010;
            2'd3:    exp_ack = 3'b100;
            default: exp_ack = 3'b000;
        endcase
        if (exp_err) exp_ack = 3'b000;

        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            check({tag, "_busy_rd"},    32'(mem_read),  32'(!exp_wr));
            check({tag, "_busy_wr"},    32'(mem_write), 32'(exp_wr));
            check({tag, "_busy_owner"}, 32'(owner),     32'(exp_owner));
            check({tag, "_busy_addr"},  mem_addr,       exp_addr);
            if (exp_wr) check({tag, "_busy_wdata"}, mem_wdata, exp_wdata);
            check({tag, "_busy_noack"}, 32'({s_ack, d_ack, f_ack}), 32'd0);
            if (i == 1) begin
                if (drop[0]) f_req = 1'b0;
                if (drop[1]) d_req = 1'b0;
                if (drop[2]) s_req = 1'b0;
            end
        end

        @(negedge clk);
        check({tag, "_resp_ack"},   32'({s_ack, d_ack, f_ack}), 32'(exp_ack));
        check({tag, "_resp_err"},   32'(err),                   32'(exp_err));
        check({tag, "_resp_rdata"}, rdata,                      exp_rdata);
        check({tag, "_resp_strb"},  32'({mem_read, mem_write}), 32'd0);
        check({tag, "_resp_owner"}, 32'(owner),                 32'(exp_owner));

        @(negedge clk);
        check({tag, "_idle_ack"},   32'({s_ack, d_ack, f_ack, err}), 32'd0);
        check({tag, "_idle_owner"}, 32'(owner),                      32'd0);
        check({tag, "_idle_strb"},  32'({mem_read, mem_write}),      32'd0);

        n_txn++;
        $display("txn %0d %s owner=%0d addr=0x%08h rdata=0x%08h err=%0b",
                 n_txn, tag, exp_owner, exp_addr, rdata, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        f_req = 1'b0; d_req = 1'b0; s_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; s_addr = '0; d_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_owner", 32'(owner),                       32'd0);
        check("rst_strb",  32'({mem_read, mem_write}),       32'd0);
        check("rst_ack",   32'({s_ack, d_ack, f_ack, err}),  32'd0);
        check("rst_rdata", rdata,                            32'd0);
        check("rst_addr",  mem_addr,                         32'd0);
        check("rst_wdata", mem_wdata,                        32'd0);
        $display("txn reset checked");
        rst = 1'b0;
        @(negedge clk);

        // Fetch only, zero-wait memory.
        wait_cfg = 0; rdata_cfg = 32'hDEAD_BEEF;
        f_req = 1'b1; f_addr = 32'h40;
        check_txn("fetch_basic", 2'd1, 32'h40, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 3'b001);

        // All three at once: data write, then string, then fetch.
        rdata_cfg = 32'h1111_1111;
        f_req = 1'b1; f_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h5;
        s_req = 1'b1; s_addr = 32'h200;
        check_txn("all_data",  2'd2, 32'h100, 1'b1, 32'h5, 1, 32'hDEAD_BEEF, 1'b0, 3'b010);
        check_txn("all_str",   2'd3, 32'h200, 1'b0, 32'h0, 1, 32'h1111_1111, 1'b0, 3'b100);
        check_txn("all_fetch", 2'd1, 32'h300, 1'b0, 32'h0, 1, 32'h1111_1111, 1'b0, 3'b001);

        // Starvation: data held high with fetch pending.
        rdata_cfg = 32'h2222_2222;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        f_req = 1'b1; f_addr = 32'h600;
        for (int n = 0; n < SMAX; n++) begin
            check_txn("starve_data", 2'd2, 32'h500, 1'b0, 32'h0, 1, 32'h2222_2222, 1'b0, 3'b000);
        end
        rdata_cfg = 32'h3333_3333;
        check_txn("starve_fetch", 2'd1, 32'h600, 1'b0, 32'h0, 1, 32'h3333_3333, 1'b0, 3'b011);

        // Timeout on a write: 8 strobe cycles, err, rdata untouched.
        wait_cfg = 255;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'hCAFE;
        check_txn("timeout", 2'd2, 32'h700, 1'b1, 32'hCAFE, TMO, 32'h3333_3333, 1'b1, 3'b010);

        // mem_ready while idle must not do anything.
        ready_force = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_idle_ack",   32'({s_ack, d_ack, f_ack, err}), 32'd0);
        check("ready_idle_owner", 32'(owner),                      32'd0);
        check("ready_idle_rdata", rdata,                           32'h3333_3333);
        ready_force = 1'b0;
        $display("txn idle mem_ready ignored checked");
        @(negedge clk);

        // String dropped after grant, memory answers in BUSY cycle 4.
        wait_cfg = 3; rdata_cfg = 32'h4444_4444;
        s_req = 1'b1; s_addr = 32'h900;
        check_txn("str_drop", 2'd3, 32'h900, 1'b0, 32'h0, 4, 32'h4444_4444, 1'b0, 3'b100);

        // Reset during BUSY cycle 3 of a string read.
        wait_cfg = 255;
        s_req = 1'b1; s_addr = 32'h800;
        @(negedge clk);
        check("rstbusy_c1_rd", 32'(mem_read), 32'd1);
        s_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstbusy_c3_rd", 32'(mem_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstbusy_strb",  32'({mem_read, mem_write}),      32'd0);
        check("rstbusy_ack",   32'({s_ack, d_ack, f_ack, err}), 32'd0);
        check("rstbusy_owner", 32'(owner),                      32'd0);
        check("rstbusy_rdata", rdata,                           32'd0);
        check("rstbusy_addr",  mem_addr,                        32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy_after_ack",   32'({s_ack, d_ack, f_ack, err}), 32'd0);
        check("rstbusy_after_owner", 32'(owner),                      32'd0);
        $display("txn reset mid-busy checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
